// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel gradient stage.
// Buffers the two previous image rows and presents each complete neighbourhood on P0..P8.
module sobel_window_gen #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       sof,
  output logic [7:0] P0,
  output logic [7:0] P1,
  output logic [7:0] P2,
  output logic [7:0] P3,
  output logic [7:0] P4,
  output logic [7:0] P5,
  output logic [7:0] P6,
  output logic [7:0] P7,
  output logic [7:0] P8,
  output logic       start_calculations,
  output logic       frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned PIX_W = 8;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [PIX_W-1:0] r_win [9];
  logic             r_start;
  logic             r_frame_done;
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];

  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_win_ok;
  logic [PIX_W-1:0] w_lb1_rd;
  logic [PIX_W-1:0] w_lb2_rd;

  // sof forces the accepted pixel to (0,0) regardless of where the counters are
  assign w_col      = sof ? '0 : r_col;
  assign w_row      = sof ? '0 : r_row;
  assign w_col_last = (w_col == COL_W'(IMG_WIDTH - 1));
  assign w_row_last = (w_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_win_ok   = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
  assign w_lb1_rd   = r_lb1[w_col];
  assign w_lb2_rd   = r_lb2[w_col];

  // Position counters point at the next pixel to be accepted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixel_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : ROW_W'(w_row + 1'b1);
      end else begin
        r_col <= COL_W'(w_col + 1'b1);
        r_row <= w_row;
      end
    end
  end

  // Line buffers are plain RAM: no reset, stale rows are masked by the row gate
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      r_lb2[w_col] <= w_lb1_rd;
      r_lb1[w_col] <= pixel_in;
    end
  end

  // Window shifts left on every accepted pixel; new right column comes from the buffers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_start      <= pixel_valid && w_win_ok;
      r_frame_done <= pixel_valid && w_row_last && w_col_last;
      if (pixel_valid) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= w_lb2_rd;
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= w_lb1_rd;
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= pixel_in;
      end
    end
  end

  assign P0                 = r_win[0];
  assign P1                 = r_win[1];
  assign P2                 = r_win[2];
  assign P3                 = r_win[3];
  assign P4                 = r_win[4];
  assign P5                 = r_win[5];
  assign P6                 = r_win[6];
  assign P7                 = r_win[7];
  assign P8                 = r_win[8];
  assign start_calculations = r_start;
  assign frame_done         = r_frame_done;

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that feeds the Sobel gradient stage. It accepts 8-bit grayscale pixels in raster order and buffers the two previous image rows. For every pixel position whose full 3x3 neighbourhood is available, it presents the neighbourhood on P0..P8 and pulses start_calculations for one cycle. Its outputs drive the horizontal and vertical gradient blocks directly.

## Interface
- IMG_WIDTH, 640: pixels per row; legal range is 3 or more.
- IMG_HEIGHT, 480: rows per frame; legal range is 3 or more.
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- pixel_in  in  8  input pixel, unsigned grayscale.
- pixel_valid  in  1  pixel_in is accepted on the rising edge when this is high.
- sof  in  1  start of frame; meaningful only together with pixel_valid.
- P0..P8  out  8 each  registered window; P0 P1 P2 = top row, P3 P4 P5 = middle row, P6 P7 P8 = bottom row, each row ordered left to right.
- start_calculations  out  1  one-cycle pulse: P0..P8 hold a new, complete window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Position tracking:
  - col counter: 0..IMG_WIDTH-1. row counter: 0..IMG_HEIGHT-1. Both point at the position of the next pixel to be accepted.
  - Only accepted pixels advance state. When pixel_valid is low, counters, line buffers and window registers all hold.
  - Column wrap: col == IMG_WIDTH-1 on acceptance → col = 0, row + 1.
  - Frame wrap: row == IMG_HEIGHT-1 and col == IMG_WIDTH-1 on acceptance → row = 0, col = 0, frame_done pulse.
- Line buffers:
  - Two buffers, lb1 (row r-1) and lb2 (row r-2), each IMG_WIDTH x 8, indexed by col.
  - On accepting pixel (r,c): read lb2[c] and lb1[c], then write lb2[c] = lb1[c] and lb1[c] = pixel_in.
  - Read-before-write within the same cycle.
- Window shift:
  - Each column of the window shifts left by one position.
  - The new right column is P2 = lb2[c], P5 = lb1[c], P8 = pixel_in.
- Window validity: the window is complete when the accepted pixel has r ≥ 2 and c ≥ 2. It is then centred at (r-1, c-1), with P0 = (r-2, c-2) and P8 = (r, c).
- For c < 2, the window holds stale columns from the previous row. The window shift is still performed, but start_calculations is suppressed.
- Windows per frame: exactly (IMG_WIDTH-2)·(IMG_HEIGHT-2). No border padding; edge pixels produce no window.
- sof:
  - sof with pixel_valid: the pixel is taken as (0,0) regardless of the counter values, and the counters continue from (0,1).
  - A truncated previous frame produces no frame_done.
  - sof without pixel_valid is ignored.
- Line buffer contents are not cleared by sof or reset. The r ≥ 2 gate masks stale data.

## Timing
- Reset (n_rst low, asynchronous): P0..P8 = 0, start_calculations = 0, frame_done = 0, row = 0, col = 0. Line buffer RAM is not reset.
- Latency: the pixel accepted at edge k produces its window on P0..P8, with start_calculations high, during the cycle after edge k, i.e. 1 cycle.
- P0..P8 hold their values until the next accepted pixel. They update on every accepted pixel, including non-valid positions, so consumers sample only while start_calculations is high.
- frame_done goes high in the same cycle as the final window's start_calculations.
- Back-to-back acceptance at one pixel per cycle is supported. There is no backpressure and no ready signal.
- Reset mid-frame: the next accepted pixel is (0,0). No window is emitted until row 2 col 2 of the new frame.

## Test plan
- Basic 4x4 frame (IMG_WIDTH = 4, IMG_HEIGHT = 4, pixel = row·16 + col, continuous valid):
  - Exactly 4 start_calculations pulses.
  - First pulse, one cycle after accepting pixel 0x22, shows P0..P8 = 00 01 02 10 11 12 20 21 22.
  - Last pulse shows 11 12 13 21 22 23 31 32 33.
  - frame_done coincides with the last pulse.
- Same frame with pixel_valid low on every other cycle: identical window sequence and values, with pulses spaced accordingly.
- Two consecutive frames, second pixel = 0x80 + row·16 + col:
  - Second frame's first window is 80 81 82 90 91 92 A0 A1 A2.
  - No window is emitted during rows 0–1 of frame 2.
- sof asserted at frame-1 position (2,1):
  - No frame_done for frame 1.
  - Following 16 pixels form a normal frame with 4 windows and frame_done.
- n_rst pulled low at position (3,0):
  - All outputs read 0 immediately, without waiting for a clock edge.
  - After release, a full frame yields 4 correct windows.
- Column-wrap guard: at positions (2,0) and (2,1) of a 4x4 frame, start_calculations stays 0 even though P0..P8 change.
